// File: rtl/cpu_control_unit.sv
// Control-unit FSM for the 8-bit accumulator CPU: sequences program loading,
// fetch/decode/execute, the IN handshake and halt, driving every datapath strobe.
module cpu_control_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OPC_W  = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [OPC_W-1:0]  IR,
    input  logic              Aeq0,
    input  logic              Apos,
    input  logic              Run,
    input  logic              ProgMode,
    input  logic              ByteValid,
    input  logic              Enter,
    output logic              IRload,
    output logic              PCload,
    output logic              JMPmux,
    output logic              Meminst,
    output logic              MemWr,
    output logic              Aload,
    output logic              Sub,
    output logic [1:0]        Asel,
    output logic              Halt,
    output logic              programEn,
    output logic              Addrload,
    output logic              PRload,
    output logic [ADDR_W-1:0] AddrSel,
    output logic [3:0]        State
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PWAIT   = 4'd1,
        S_PWRITE  = 4'd2,
        S_FETCH   = 4'd3,
        S_DECODE  = 4'd4,
        S_X_LOAD  = 4'd5,
        S_X_STORE = 4'd6,
        S_X_ADD   = 4'd7,
        S_X_SUB   = 4'd8,
        S_X_IN    = 4'd9,
        S_IN_REL  = 4'd10,
        S_X_JZ    = 4'd11,
        S_X_JPOS  = 4'd12,
        S_HALTED  = 4'd13
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_IN    = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JZ    = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JPOS  = OPC_W'(6);

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   cnt, cnt_next;

    // State and program-load address counter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign State = state;

    // Next-state and strobe decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        IRload     = 1'b0;
        PCload     = 1'b0;
        JMPmux     = 1'b0;
        Meminst    = 1'b0;
        MemWr      = 1'b0;
        Aload      = 1'b0;
        Sub        = 1'b0;
        Asel       = ASEL_ALU;
        Halt       = 1'b0;
        programEn  = 1'b0;
        Addrload   = 1'b0;
        PRload     = 1'b0;
        AddrSel    = '0;

        case (state)
            S_IDLE: begin
                if (ProgMode)  state_next = S_PWAIT;
                else if (Run)  state_next = S_FETCH;
            end
            S_PWAIT: begin
                if (!ProgMode) begin
                    state_next = S_IDLE;
                end else if (ByteValid) begin
                    Addrload   = 1'b1;
                    PRload     = 1'b1;
                    AddrSel    = cnt;
                    state_next = S_PWRITE;
                end
            end
            S_PWRITE: begin
                programEn  = 1'b1;
                cnt_next   = cnt + ADDR_W'(1);
                state_next = (cnt == '1) ? S_IDLE : S_PWAIT;
            end
            S_FETCH: begin
                IRload     = 1'b1;
                PCload     = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                Meminst = 1'b1;
                case (IR)
                    OP_LOAD:  state_next = S_X_LOAD;
                    OP_STORE: state_next = S_X_STORE;
                    OP_ADD:   state_next = S_X_ADD;
                    OP_SUB:   state_next = S_X_SUB;
                    OP_IN:    state_next = S_X_IN;
                    OP_JZ:    state_next = S_X_JZ;
                    OP_JPOS:  state_next = S_X_JPOS;
                    default:  state_next = S_HALTED;
                endcase
            end
            S_X_LOAD: begin
                Meminst    = 1'b1;
                Asel       = ASEL_RAM;
                Aload      = 1'b1;
                state_next = S_FETCH;
            end
            S_X_STORE: begin
                Meminst    = 1'b1;
                MemWr      = 1'b1;
                state_next = S_FETCH;
            end
            S_X_ADD, S_X_SUB: begin
                Meminst    = 1'b1;
                Asel       = ASEL_ALU;
                Sub        = (state == S_X_SUB);
                Aload      = 1'b1;
                state_next = S_FETCH;
            end
            S_X_IN: begin
                if (Enter) begin
                    Asel       = ASEL_IN;
                    Aload      = 1'b1;
                    state_next = S_IN_REL;
                end
            end
            // A held Enter must drop before the next instruction can consume it
            S_IN_REL: begin
                if (!Enter) state_next = S_FETCH;
            end
            S_X_JZ: begin
                Meminst    = 1'b1;
                JMPmux     = 1'b1;
                PCload     = Aeq0;
                state_next = S_FETCH;
            end
            S_X_JPOS: begin
                Meminst    = 1'b1;
                JMPmux     = 1'b1;
                PCload     = Apos;
                state_next = S_FETCH;
            end
            S_HALTED: begin
                Halt = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: a small datapath around the controller plus an
// instruction-level reference model that predicts the per-cycle strobe trace.
module tb_cpu_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       irl, pcl, jmp, mi, mw, al, sb;
        logic [1:0] asel;
        logic       hlt, pen, adl, prl;
        logic [4:0] addr;
    } ov_t;

    typedef struct packed {
        logic       run, prog, bv, enter;
        logic [7:0] din;
        ov_t        exp;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, prog, bv, enter;
    logic [7:0] in_byte;

    logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
    logic       programEn, Addrload, PRload;
    logic [1:0] Asel;
    logic [4:0] AddrSel;
    logic [3:0] State;
    ov_t        obs;

    // Datapath surrounding the controller
    logic [7:0] ram [32];
    logic [7:0] ir, a, byte_lat, rdata;
    logic [4:0] pc, addr_lat, maddr;

    int   n_tests, n_fail;
    rec_t trace[$];
    logic [7:0] mdl_mem [32];
    int   fix_w, fix_h;
    logic [7:0] fix_v;

    cpu_control_unit dut (
        .Clock(clk), .Reset(rst_n), .IR(ir[7:5]), .Aeq0(a == 8'd0), .Apos(~a[7]),
        .Run(run), .ProgMode(prog), .ByteValid(bv), .Enter(enter),
        .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
        .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt),
        .programEn(programEn), .Addrload(Addrload), .PRload(PRload),
        .AddrSel(AddrSel), .State(State)
    );

    always #5 clk = ~clk;

    assign obs   = {State, IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub,
                    Asel, Halt, programEn, Addrload, PRload, AddrSel};
    assign maddr = Meminst ? ir[4:0] : pc;
    assign rdata = ram[maddr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0; ir <= '0; a <= '0; addr_lat <= '0; byte_lat <= '0;
        end else begin
            if (IRload)   ir <= rdata;
            if (PCload)   pc <= JMPmux ? ir[4:0] : pc + 5'd1;
            if (Addrload) addr_lat <= AddrSel;
            if (PRload)   byte_lat <= in_byte;
            if (Aload) begin
                case (Asel)
                    2'b00:   a <= Sub ? a - rdata : a + rdata;
                    2'b01:   a <= in_byte;
                    2'b10:   a <= rdata;
                    default: a <= 8'd0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && programEn) ram[addr_lat] <= byte_lat;
        if (rst_n && MemWr)     ram[ir[4:0]]  <= a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic push(input ov_t e, input logic r, input logic p, input logic b,
                        input logic en, input logic [7:0] d);
        rec_t x;
        x.run = r; x.prog = p; x.bv = b; x.enter = en; x.din = d; x.exp = e;
        trace.push_back(x);
    endtask

    // Expected trace for loading mdl_mem into RAM, then a 33rd strobe in IDLE
    task automatic gen_load();
        ov_t e;
        e = '0; push(e, rb(), 1'b1, 1'b0, 1'b0, rnd8());
        for (int i = 0; i < 32; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                e = '0; e.st = 4'd1; push(e, rb(), 1'b1, 1'b0, 1'b0, rnd8());
            end
            e = '0; e.st = 4'd1; e.adl = 1'b1; e.prl = 1'b1; e.addr = 5'(i);
            push(e, rb(), 1'b1, 1'b1, 1'b0, mdl_mem[i]);
            e = '0; e.st = 4'd2; e.pen = 1'b1; push(e, rb(), 1'b1, rb(), 1'b0, rnd8());
        end
        e = '0; push(e, 1'b0, 1'b0, 1'b1, 1'b0, rnd8());
    endtask

    // Instruction-level interpreter producing the expected per-cycle trace
    task automatic gen_exec(input int max_ins, input int halt_n, input bit toggle_run);
        logic [4:0] mpc;
        logic [7:0] ma, mir, v;
        int w, h;
        ov_t e;
        mpc = '0; ma = '0;
        e = '0; push(e, 1'b1, 1'b0, 1'b0, 1'b0, rnd8());
        for (int i = 0; i < max_ins; i++) begin
            mir = mdl_mem[mpc];
            e = '0; e.st = 4'd3; e.irl = 1'b1; e.pcl = 1'b1; push(e, rb(), 1'b0, 1'b0, 1'b0, rnd8());
            mpc = mpc + 5'd1;
            e = '0; e.st = 4'd4; e.mi = 1'b1; push(e, rb(), 1'b0, 1'b0, 1'b0, rnd8());
            e = '0;
            case (mir[7:5])
                3'd0: begin e.st = 4'd5; e.mi = 1; e.asel = 2'b10; e.al = 1; ma = mdl_mem[mir[4:0]]; end
                3'd1: begin e.st = 4'd6; e.mi = 1; e.mw = 1; mdl_mem[mir[4:0]] = ma; end
                3'd2: begin e.st = 4'd7; e.mi = 1; e.al = 1; ma = ma + mdl_mem[mir[4:0]]; end
                3'd3: begin e.st = 4'd8; e.mi = 1; e.al = 1; e.sb = 1; ma = ma - mdl_mem[mir[4:0]]; end
                3'd5: begin
                    e.st = 4'd11; e.mi = 1; e.jmp = 1; e.pcl = (ma == 8'd0);
                    if (ma == 8'd0) mpc = mir[4:0];
                end
                3'd6: begin
                    e.st = 4'd12; e.mi = 1; e.jmp = 1; e.pcl = ~ma[7];
                    if (!ma[7]) mpc = mir[4:0];
                end
                default: ;
            endcase
            if (mir[7:5] == 3'd7) begin
                for (int j = 0; j < halt_n; j++) begin
                    e = '0; e.st = 4'd13; e.hlt = 1'b1;
                    push(e, toggle_run ? 1'(j % 2) : rb(), rb(), rb(), rb(), rnd8());
                end
                return;
            end else if (mir[7:5] == 3'd4) begin
                w = (fix_w >= 0) ? fix_w : int'($urandom_range(0, 3));
                h = (fix_h >= 1) ? fix_h : int'($urandom_range(1, 4));
                v = (fix_w >= 0) ? fix_v : rnd8();
                for (int j = 0; j < w; j++) begin
                    e = '0; e.st = 4'd9; push(e, rb(), 1'b0, 1'b0, 1'b0, rnd8());
                end
                e = '0; e.st = 4'd9; e.asel = 2'b01; e.al = 1'b1; push(e, rb(), 1'b0, 1'b0, 1'b1, v);
                ma = v;
                for (int j = 1; j < h; j++) begin
                    e = '0; e.st = 4'd10; push(e, rb(), 1'b0, 1'b0, 1'b1, rnd8());
                end
                e = '0; e.st = 4'd10; push(e, rb(), 1'b0, 1'b0, 1'b0, rnd8());
            end else begin
                push(e, rb(), 1'b0, 1'b0, 1'b0, rnd8());
            end
        end
    endtask

    // Apply n trace records (all if n < 0), one per cycle; entry/exit at posedge+1
    task automatic play(input int n);
        rec_t x;
        int k;
        k = 0;
        while (trace.size() > 0 && (n < 0 || k < n)) begin
            x = trace.pop_front();
            run = x.run; prog = x.prog; bv = x.bv; enter = x.enter; in_byte = x.din;
            @(negedge clk);
            check($sformatf("cyc%0d_st%0d", k, x.exp.st), 32'(obs), 32'(x.exp));
            @(posedge clk); #1;
            k++;
        end
        trace.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 0; prog = 0; bv = 0; enter = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) mdl_mem[i] = 8'hE0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; fix_w = -1; fix_h = -1; fix_v = 8'h00;
        rst_n = 1'b0; run = 0; prog = 0; bv = 0; enter = 0; in_byte = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load bytes 0x00..0x1F in order
        for (int i = 0; i < 32; i++) mdl_mem[i] = 8'(i);
        gen_load(); play(-1);
        for (int i = 0; i < 32; i++) check($sformatf("load_ram%0d", i), 32'(ram[i]), 32'(i));

        // JZ taken: 7-7 == 0, jump to 5
        do_reset(); fill_halt();
        mdl_mem[0] = 8'h1E; mdl_mem[1] = 8'h7F; mdl_mem[2] = 8'hA5;
        mdl_mem[30] = 8'h07; mdl_mem[31] = 8'h07;
        gen_load(); gen_exec(10, 4, 1'b0); play(-1);
        check("jz_taken_pc", 32'(pc), 32'd6);

        // JZ not taken, HALT held with Run toggling
        do_reset(); fill_halt();
        mdl_mem[0] = 8'h1E; mdl_mem[1] = 8'h7F; mdl_mem[2] = 8'hA5;
        mdl_mem[30] = 8'h07; mdl_mem[31] = 8'h03;
        gen_load(); gen_exec(10, 20, 1'b1); play(-1);
        check("jz_not_taken_pc", 32'(pc), 32'd4);

        // IN with Enter held for 5 cycles, then STORE 0x10
        do_reset(); fill_halt();
        mdl_mem[0] = 8'h80; mdl_mem[1] = 8'h30;
        fix_w = 2; fix_h = 5; fix_v = 8'h5A;
        gen_load(); gen_exec(10, 3, 1'b0); play(-1);
        fix_w = -1; fix_h = -1;
        check("in_store_ram", 32'(ram[16]), 32'h5A);

        // Reset asserted mid X_ADD
        do_reset(); fill_halt();
        mdl_mem[0] = 8'h5F; mdl_mem[31] = 8'h03;
        gen_load(); play(-1);
        gen_exec(5, 3, 1'b0); play(3);
        check("in_x_add", 32'(State), 32'd7);
        rst_n = 1'b0;
        #1;
        check("reset_mid_add", 32'(obs), 32'd0);
        run = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("run_after_reset", 32'(State), 32'd3);

        // Random programs
        for (int p = 0; p < 12; p++) begin
            do_reset();
            for (int i = 0; i < 32; i++) mdl_mem[i] = rnd8();
            gen_load(); gen_exec(40, 3, 1'b0); play(-1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
